// File: rtl/alarm_controller.sv
// Alarm-clock control block: button handling, time/alarm editing, alarm match and ring timing.
// The state code on `mode` doubles as the observable FSM state.
module alarm_controller #(
    parameter int unsigned RING_SECONDS = 60
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic [5:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       time_load,
    output logic [5:0] load_hour,
    output logic [7:0] load_min,
    output logic [5:0] alarm_hour,
    output logic [7:0] alarm_min,
    output logic       alarm_armed,
    output logic       buzzer,
    output logic [5:0] disp_hour,
    output logic [7:0] disp_min,
    output logic [3:0] blink_mask,
    output logic [2:0] mode
);
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        ALM_HOUR = 3'd3,
        ALM_MIN  = 3'd4,
        RINGING  = 3'd5
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS);

    function automatic logic [5:0] inc_hour(input logic [5:0] h);
        if (h == 6'h23) return 6'h00;
        if (h[3:0] == 4'd9) return {h[5:4] + 2'd1, 4'd0};
        return {h[5:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [7:0] m);
        if (m == 8'h59) return 8'h00;
        if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
        return {m[7:4], m[3:0] + 4'd1};
    endfunction

    state_t     state_q, state_d;
    logic [2:0] btn_s1_q, btn_s2_q, btn_s3_q;
    logic [1:0] warm_q, warm_d;
    logic [5:0] edit_hour_q, edit_hour_d, alarm_hour_q, alarm_hour_d, load_hour_q, load_hour_d;
    logic [7:0] edit_min_q, edit_min_d, alarm_min_q, alarm_min_d, load_min_q, load_min_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       armed_q, armed_d, buzzer_q, buzzer_d, time_load_q, time_load_d;
    logic       match_q, match_d, phase_q, phase_d;
    logic [3:0] blink_q, blink_d;
    logic [2:0] press;
    logic       p_alarm, p_mode, p_inc;

    // Edge detection is held off until the synchronizer has refilled after reset,
    // so a button already held at release never looks like a fresh press.
    assign press   = btn_s2_q & ~btn_s3_q & {3{warm_q == 2'd3}};
    assign p_alarm = press[2];
    assign p_mode  = press[1] & ~press[2];
    assign p_inc   = press[0] & ~press[1] & ~press[2];
    assign warm_d  = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        edit_hour_d  = edit_hour_q;
        edit_min_d   = edit_min_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        load_hour_d  = load_hour_q;
        load_min_d   = load_min_q;
        ring_cnt_d   = ring_cnt_q;
        armed_d      = armed_q;
        buzzer_d     = buzzer_q;
        time_load_d  = 1'b0;
        match_d      = (cur_hour == alarm_hour_q) && (cur_min == alarm_min_q) && (cur_sec == 8'h00);

        unique case (state_q)
            RUN: begin
                if (p_alarm) armed_d = ~armed_q;
                else if (p_mode) begin
                    state_d     = SET_HOUR;
                    edit_hour_d = cur_hour;
                    edit_min_d  = cur_min;
                end else if (match_d && !match_q && armed_q) begin
                    state_d    = RINGING;
                    ring_cnt_d = 8'd0;
                    buzzer_d   = 1'b1;
                end
            end
            SET_HOUR: begin
                if (p_alarm) armed_d = ~armed_q;
                else if (p_mode) state_d = SET_MIN;
                else if (p_inc) edit_hour_d = inc_hour(edit_hour_q);
            end
            SET_MIN: begin
                if (p_alarm) armed_d = ~armed_q;
                else if (p_mode) begin
                    state_d     = ALM_HOUR;
                    time_load_d = 1'b1;
                    load_hour_d = edit_hour_q;
                    load_min_d  = edit_min_q;
                end else if (p_inc) edit_min_d = inc_min(edit_min_q);
            end
            ALM_HOUR: begin
                if (p_alarm) armed_d = ~armed_q;
                else if (p_mode) state_d = ALM_MIN;
                else if (p_inc) alarm_hour_d = inc_hour(alarm_hour_q);
            end
            ALM_MIN: begin
                if (p_alarm) armed_d = ~armed_q;
                else if (p_mode) state_d = RUN;
                else if (p_inc) alarm_min_d = inc_min(alarm_min_q);
            end
            RINGING: begin
                // A silence press wins over a coinciding timeout; armed is left alone either way.
                if (p_alarm) begin
                    state_d  = RUN;
                    buzzer_d = 1'b0;
                end else if (tick_1hz) begin
                    if (ring_cnt_q + 8'd1 == RING_LAST) begin
                        state_d  = RUN;
                        buzzer_d = 1'b0;
                    end else begin
                        buzzer_d   = ~buzzer_q;
                        ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        phase_d = (state_d != state_q) ? 1'b1 : (tick_1hz ? ~phase_q : phase_q);
        blink_d = 4'b0000;
        if (!phase_d) begin
            if (state_d == SET_HOUR || state_d == ALM_HOUR) blink_d = 4'b1100;
            else if (state_d == SET_MIN || state_d == ALM_MIN) blink_d = 4'b0011;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            btn_s1_q     <= 3'b000;
            btn_s2_q     <= 3'b000;
            btn_s3_q     <= 3'b000;
            warm_q       <= 2'd0;
            edit_hour_q  <= 6'h00;
            edit_min_q   <= 8'h00;
            alarm_hour_q <= 6'h06;
            alarm_min_q  <= 8'h00;
            load_hour_q  <= 6'h00;
            load_min_q   <= 8'h00;
            ring_cnt_q   <= 8'd0;
            armed_q      <= 1'b0;
            buzzer_q     <= 1'b0;
            time_load_q  <= 1'b0;
            match_q      <= 1'b0;
            phase_q      <= 1'b1;
            blink_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            btn_s1_q     <= {btn_alarm, btn_mode, btn_inc};
            btn_s2_q     <= btn_s1_q;
            btn_s3_q     <= btn_s2_q;
            warm_q       <= warm_d;
            edit_hour_q  <= edit_hour_d;
            edit_min_q   <= edit_min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            load_hour_q  <= load_hour_d;
            load_min_q   <= load_min_d;
            ring_cnt_q   <= ring_cnt_d;
            armed_q      <= armed_d;
            buzzer_q     <= buzzer_d;
            time_load_q  <= time_load_d;
            match_q      <= match_d;
            phase_q      <= phase_d;
            blink_q      <= blink_d;
        end
    end

    always_comb begin
        disp_hour = cur_hour;
        disp_min  = cur_min;
        if (state_q == SET_HOUR || state_q == SET_MIN) begin
            disp_hour = edit_hour_q;
            disp_min  = edit_min_q;
        end else if (state_q == ALM_HOUR || state_q == ALM_MIN) begin
            disp_hour = alarm_hour_q;
            disp_min  = alarm_min_q;
        end
    end

    assign mode        = state_q;
    assign time_load   = time_load_q;
    assign load_hour   = load_hour_q;
    assign load_min    = load_min_q;
    assign alarm_hour  = alarm_hour_q;
    assign alarm_min   = alarm_min_q;
    assign alarm_armed = armed_q;
    assign buzzer      = buzzer_q;
    assign blink_mask  = blink_q;
endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter RING_SECONDS, default 60, number of 1 Hz ticks the alarm rings before auto-stop (range 1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk_in  in  1  system clock (PLL output domain).
- reset  in  1  asynchronous, active-low; asserts immediately, releases on clk_in.
- tick_1hz  in  1  single-cycle pulse once per second, synchronous to clk_in.
- btn_mode  in  1  debounced level, asynchronous to clk_in.
- btn_inc  in  1  debounced level, asynchronous to clk_in.
- btn_alarm  in  1  debounced level, asynchronous to clk_in.
- cur_hour  in  6  running hours as BCD {tens[1:0], units[3:0]}.
- cur_min  in  8  running minutes as BCD {tens, units}.
- cur_sec  in  8  running seconds as BCD {tens, units}.
- time_load  out  1  one-cycle pulse; time counters load load_hour/load_min and set seconds to 00.
- load_hour  out  6  BCD hour to load.
- load_min  out  8  BCD minute to load.
- alarm_hour  out  6  stored alarm hour, BCD.
- alarm_min  out  8  stored alarm minute, BCD.
- alarm_armed  out  1  alarm enabled.
- buzzer  out  1  buzzer drive.
- disp_hour  out  6  hour value for the display mux.
- disp_min  out  8  minute value for the display mux.
- blink_mask  out  4  per-digit blanking request, [3]=hour tens .. [0]=minute units.
- mode  out  3  state code: RUN=0, SET_HOUR=1, SET_MIN=2, ALM_HOUR=3, ALM_MIN=4, RINGING=5.

Function
REQ-003 Each button SHALL pass a 2-flop synchronizer; a press is the rising edge of the synchronized level, one cycle wide, 3 clk_in after the input edge.
REQ-004 Same-cycle presses SHALL be prioritised btn_alarm > btn_mode > btn_inc; lower-priority presses are dropped.
REQ-005 btn_mode press transitions:
- RUN->SET_HOUR, copying cur_hour/cur_min into the edit registers.
- SET_HOUR->SET_MIN.
- SET_MIN->ALM_HOUR, with time_load=1 for exactly that cycle carrying the edit registers.
- ALM_HOUR->ALM_MIN.
- ALM_MIN->RUN.
REQ-006 btn_inc press SHALL increment, in BCD:
- SET_HOUR: edit hour, wrapping 23->00.
- SET_MIN: edit minute, wrapping 59->00.
- ALM_HOUR: alarm hour, wrapping 23->00.
- ALM_MIN: alarm minute, wrapping 59->00.
- btn_inc SHALL be ignored in RUN and RINGING.
REQ-007 btn_alarm press SHALL toggle alarm_armed in states 0-4; in RINGING it SHALL go to RUN with buzzer=0 next cycle and alarm_armed unchanged.
REQ-008 Registered flag match SHALL equal (cur_hour==alarm_hour && cur_min==alarm_min && cur_sec==8'h00), evaluated every cycle.
REQ-009 RUN->RINGING SHALL occur when the current-cycle match is 1, the registered match is 0, and alarm_armed=1; a match rising edge outside RUN SHALL be lost.
REQ-010 Entering RINGING SHALL clear the ring counter and set buzzer=1. Each tick_1hz SHALL toggle buzzer and increment the counter; when the counter reaches RING_SECONDS the block SHALL go to RUN with buzzer=0.
REQ-011 If timeout and btn_alarm press occur in the same cycle, the block SHALL go to RUN once, with alarm_armed unchanged.
REQ-012 btn_mode SHALL be ignored in RINGING.
REQ-013 disp_hour/disp_min SHALL show:
- edit registers in SET_HOUR/SET_MIN;
- alarm registers in ALM_HOUR/ALM_MIN;
- cur_hour/cur_min in RUN/RINGING.
REQ-014 Blink phase SHALL be set to 1 on every state change and toggled by tick_1hz.
REQ-015 blink_mask SHALL be 4'b1100 in SET_HOUR/ALM_HOUR and 4'b0011 in SET_MIN/ALM_MIN when the phase is 0; otherwise 4'b0000.
REQ-016 All outputs SHALL be registered, except disp_hour/disp_min, which are a combinational mux of registered state and inputs.

Reset
REQ-017 While reset=0 the block SHALL hold: state RUN, mode=0, alarm_hour=6'h06, alarm_min=8'h00, edit registers 00:00, alarm_armed=0, buzzer=0, time_load=0, blink_mask=0, synchronizers 0, match flag 0, ring counter 0.
REQ-018 Reset asserted during RINGING or a SET state SHALL abort immediately with no time_load pulse.
REQ-019 A button held high through reset release SHALL NOT produce a press.

Verification
REQ-020 Reset; cur=12:34:56; pulse btn_mode, btn_inc x3, btn_mode, btn_inc x30, btn_mode -> single time_load with load_hour=6'h15, load_min=8'h04; mode=3.
REQ-021 In SET_HOUR from edit 22, btn_inc x2 -> 23 then 00; in SET_MIN from 58, btn_inc x2 -> 59 then 00.
REQ-022 Alarm 06:00, armed; drive cur 05:59:59 then 06:00:00 -> mode=5, buzzer=1 next cycle; with RING_SECONDS=4, four ticks -> buzzer 1,0,1,0,0 and mode=0.
REQ-023 While RINGING, pulse btn_alarm together with btn_mode -> mode=0, buzzer=0, alarm_armed=1.
REQ-024 Alarm disarmed or mode=1 at 06:00:00 -> no RINGING; assert reset mid-SET_MIN -> mode=0, time_load never pulses.
